// File: rtl/dcache_tbus_arbiter.sv
// ---------------------------------------------------------------------------
// dcache_tbus_arbiter
//
// Shares the single dcache tbus request port between the load unit (LDU) and
// the store queue (SQ). One requester is granted at a time and owns the port
// until the dcache reports operation_done; completion and read data are routed
// back to the owner. Completions of loads killed by a redirect flush are
// suppressed; SQ stores are committed and never killed.
//
// Optional feature macro: DCACHE_TBUS_ARB_STARVE_EN
//   defined   : after STARVE_LIMIT consecutive LDU grants taken while the SQ
//               was waiting, the SQ is forced ahead of the LDU.
//   undefined : strict LDU-over-SQ priority, STARVE_LIMIT unused.
//
// Ports
//   clock, reset                 sole clock, synchronous active-high reset
//   flush_valid                  redirect flush (kills LDU request / LDU op)
//   ldu2arb_tbus_*               LDU request channel, read data and done
//   sq2arb_tbus_*                SQ request channel, read data and done
//   arb2dc_tbus_*                forwarded request channel to the dcache,
//                                dcache read data and completion pulse
// ---------------------------------------------------------------------------
module dcache_tbus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush_valid,

  input  logic        ldu2arb_tbus_index_valid,
  output logic        ldu2arb_tbus_index_ready,
  input  logic [63:0] ldu2arb_tbus_index,
  input  logic [63:0] ldu2arb_tbus_write_data,
  input  logic [63:0] ldu2arb_tbus_write_mask,
  input  logic [1:0]  ldu2arb_tbus_operation_type,
  output logic [63:0] ldu2arb_tbus_read_data,
  output logic        ldu2arb_tbus_operation_done,

  input  logic        sq2arb_tbus_index_valid,
  output logic        sq2arb_tbus_index_ready,
  input  logic [63:0] sq2arb_tbus_index,
  input  logic [63:0] sq2arb_tbus_write_data,
  input  logic [63:0] sq2arb_tbus_write_mask,
  input  logic [1:0]  sq2arb_tbus_operation_type,
  output logic [63:0] sq2arb_tbus_read_data,
  output logic        sq2arb_tbus_operation_done,

  output logic        arb2dc_tbus_index_valid,
  input  logic        arb2dc_tbus_index_ready,
  output logic [63:0] arb2dc_tbus_index,
  output logic [63:0] arb2dc_tbus_write_data,
  output logic [63:0] arb2dc_tbus_write_mask,
  output logic [1:0]  arb2dc_tbus_operation_type,
  input  logic [63:0] arb2dc_tbus_read_data,
  input  logic        arb2dc_tbus_operation_done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t state_reg, state_next;
  logic   owner_reg, owner_next;   // 0 = LDU, 1 = SQ
  logic   kill_reg,  kill_next;

  logic   ldu_elig;
  logic   sq_elig;
  logic   sq_first;
  logic   grant_ldu;
  logic   grant_sq;
  logic   fire;
  logic   busy_done;

`ifdef DCACHE_TBUS_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;

  assign sq_first = (starve_cnt_reg == CNT_LIMIT);

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (fire && grant_sq) begin
      starve_cnt_next = '0;
    end else if (state_reg == ST_IDLE && !sq2arb_tbus_index_valid) begin
      starve_cnt_next = '0;
    end else if (fire && grant_ldu && sq2arb_tbus_index_valid &&
                 starve_cnt_reg != CNT_LIMIT) begin
      // Saturating: once at the limit the SQ wins the next IDLE grant anyway.
      starve_cnt_next = starve_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end
`else
  assign sq_first = 1'b0;

  // A zero limit is meaningless; with the feature compiled out the parameter
  // has no effect, so this degenerate-case block is intentionally empty.
  if (STARVE_LIMIT == 0) begin : g_limit_degenerate
  end
`endif

  // Grant selection: only an IDLE arbiter grants. A flushed LDU request is not
  // eligible, so it can never be forwarded during a flush cycle.
  always_comb begin
    ldu_elig  = ldu2arb_tbus_index_valid & ~flush_valid;
    sq_elig   = sq2arb_tbus_index_valid;
    grant_ldu = 1'b0;
    grant_sq  = 1'b0;
    if (state_reg == ST_IDLE) begin
      if (sq_first && sq_elig) begin
        grant_sq = 1'b1;
      end else if (ldu_elig) begin
        grant_ldu = 1'b1;
      end else if (sq_elig) begin
        grant_sq = 1'b1;
      end
    end
  end

  assign fire      = (grant_ldu | grant_sq) & arb2dc_tbus_index_ready;
  assign busy_done = (state_reg == ST_BUSY) & arb2dc_tbus_operation_done;

  // Request forwarding and completion routing.
  always_comb begin
    arb2dc_tbus_index_valid     = grant_ldu | grant_sq;
    arb2dc_tbus_index           = '0;
    arb2dc_tbus_write_data      = '0;
    arb2dc_tbus_write_mask      = '0;
    arb2dc_tbus_operation_type  = '0;
    ldu2arb_tbus_index_ready    = grant_ldu & arb2dc_tbus_index_ready;
    sq2arb_tbus_index_ready     = grant_sq  & arb2dc_tbus_index_ready;
    ldu2arb_tbus_read_data      = '0;
    sq2arb_tbus_read_data       = '0;
    ldu2arb_tbus_operation_done = 1'b0;
    sq2arb_tbus_operation_done  = 1'b0;

    if (grant_ldu) begin
      arb2dc_tbus_index          = ldu2arb_tbus_index;
      arb2dc_tbus_write_data     = ldu2arb_tbus_write_data;
      arb2dc_tbus_write_mask     = ldu2arb_tbus_write_mask;
      arb2dc_tbus_operation_type = ldu2arb_tbus_operation_type;
    end else if (grant_sq) begin
      arb2dc_tbus_index          = sq2arb_tbus_index;
      arb2dc_tbus_write_data     = sq2arb_tbus_write_data;
      arb2dc_tbus_write_mask     = sq2arb_tbus_write_mask;
      arb2dc_tbus_operation_type = sq2arb_tbus_operation_type;
    end

    if (busy_done) begin
      if (owner_reg) begin
        sq2arb_tbus_read_data      = arb2dc_tbus_read_data;
        sq2arb_tbus_operation_done = 1'b1;
      end else begin
        // Data is still routed for a killed load; only the done is withheld,
        // including a flush that lands in the completion cycle itself.
        ldu2arb_tbus_read_data      = arb2dc_tbus_read_data;
        ldu2arb_tbus_operation_done = ~kill_reg & ~flush_valid;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    kill_next  = kill_reg;
    case (state_reg)
      ST_IDLE: begin
        if (fire) begin
          state_next = ST_BUSY;
          owner_next = grant_sq;
          kill_next  = grant_ldu & flush_valid;
        end
      end
      ST_BUSY: begin
        if (flush_valid && !owner_reg) begin
          kill_next = 1'b1;
        end
        if (arb2dc_tbus_operation_done) begin
          state_next = ST_IDLE;
          kill_next  = 1'b0;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      owner_reg <= 1'b0;
      kill_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      kill_reg  <= kill_next;
    end
  end

endmodule

// File: tb/tb_dcache_tbus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dcache_tbus_arbiter
//
// Self-checking bench for dcache_tbus_arbiter. A transaction-level model (a
// queue of outstanding operations plus an LDU grant-streak counter) predicts
// every output each cycle; directed scenarios add literal expectations, then
// a randomized phase exercises the arbiter against the model.
// ---------------------------------------------------------------------------
module tb_dcache_tbus_arbiter;

  localparam int LIM = 2;
`ifdef DCACHE_TBUS_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        flush_valid;
  logic        ldu_valid, ldu_ready, ldu_done;
  logic [63:0] ldu_index, ldu_wdata, ldu_wmask, ldu_rdata;
  logic [1:0]  ldu_op;
  logic        sq_valid, sq_ready, sq_done;
  logic [63:0] sq_index, sq_wdata, sq_wmask, sq_rdata;
  logic [1:0]  sq_op;
  logic        dc_valid, dc_ready, dc_done;
  logic [63:0] dc_index, dc_wdata, dc_wmask, dc_rdata;
  logic [1:0]  dc_op;

  always #5 clock = ~clock;

  dcache_tbus_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clock                       (clock),
    .reset                       (reset),
    .flush_valid                 (flush_valid),
    .ldu2arb_tbus_index_valid    (ldu_valid),
    .ldu2arb_tbus_index_ready    (ldu_ready),
    .ldu2arb_tbus_index          (ldu_index),
    .ldu2arb_tbus_write_data     (ldu_wdata),
    .ldu2arb_tbus_write_mask     (ldu_wmask),
    .ldu2arb_tbus_operation_type (ldu_op),
    .ldu2arb_tbus_read_data      (ldu_rdata),
    .ldu2arb_tbus_operation_done (ldu_done),
    .sq2arb_tbus_index_valid     (sq_valid),
    .sq2arb_tbus_index_ready     (sq_ready),
    .sq2arb_tbus_index           (sq_index),
    .sq2arb_tbus_write_data      (sq_wdata),
    .sq2arb_tbus_write_mask      (sq_wmask),
    .sq2arb_tbus_operation_type  (sq_op),
    .sq2arb_tbus_read_data       (sq_rdata),
    .sq2arb_tbus_operation_done  (sq_done),
    .arb2dc_tbus_index_valid     (dc_valid),
    .arb2dc_tbus_index_ready     (dc_ready),
    .arb2dc_tbus_index           (dc_index),
    .arb2dc_tbus_write_data      (dc_wdata),
    .arb2dc_tbus_write_mask      (dc_wmask),
    .arb2dc_tbus_operation_type  (dc_op),
    .arb2dc_tbus_read_data       (dc_rdata),
    .arb2dc_tbus_operation_done  (dc_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: an outstanding operation record (who owns the port, was it killed)
  // and the number of LDU grants taken back-to-back while the SQ waited.
  typedef struct {
    bit who;      // 0 = LDU, 1 = SQ
    bit killed;
  } op_t;
  op_t q[$];
  int  streak;
  int  winner;    // -1 none, 0 LDU, 1 SQ

  logic        e_dc_valid, e_ldu_ready, e_sq_ready, e_ldu_done, e_sq_done;
  logic [63:0] e_index, e_wdata, e_wmask, e_ldu_rdata, e_sq_rdata;
  logic [1:0]  e_op;

  bit log_en;
  bit grant_log[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_eval();
    e_dc_valid = 0; e_ldu_ready = 0; e_sq_ready = 0; e_ldu_done = 0; e_sq_done = 0;
    e_index = 0; e_wdata = 0; e_wmask = 0; e_op = 0; e_ldu_rdata = 0; e_sq_rdata = 0;
    winner = -1;
    if (q.size() == 0) begin
      if (STARVE && streak == LIM && sq_valid) winner = 1;
      else if (ldu_valid && !flush_valid)      winner = 0;
      else if (sq_valid)                       winner = 1;
      if (winner == 0) begin
        e_dc_valid = 1; e_ldu_ready = dc_ready;
        e_index = ldu_index; e_wdata = ldu_wdata; e_wmask = ldu_wmask; e_op = ldu_op;
      end else if (winner == 1) begin
        e_dc_valid = 1; e_sq_ready = dc_ready;
        e_index = sq_index; e_wdata = sq_wdata; e_wmask = sq_wmask; e_op = sq_op;
      end
    end else if (dc_done) begin
      if (q[0].who) begin
        e_sq_done = 1; e_sq_rdata = dc_rdata;
      end else begin
        e_ldu_rdata = dc_rdata;
        e_ldu_done  = !q[0].killed && !flush_valid;
      end
    end
  endtask

  task automatic model_update();
    bit fire;
    if (reset) begin
      q.delete();
      streak = 0;
    end else if (q.size() == 0) begin
      fire = (winner >= 0) && dc_ready;
      if (fire) q.push_back('{who: (winner == 1), killed: (winner == 0) && flush_valid});
      if (fire && winner == 1)       streak = 0;
      else if (!sq_valid)            streak = 0;
      else if (fire && winner == 0)  streak = streak + 1;
    end else begin
      if (flush_valid && !q[0].who) q[0].killed = 1;
      if (dc_done) void'(q.pop_front());
    end
  endtask

  // Settle at the falling edge: compare every output against the model.
  task automatic settle();
    @(negedge clock);
    model_eval();
    chk("dc_valid",  dc_valid,  e_dc_valid);
    chk("dc_index",  dc_index,  e_index);
    chk("dc_wdata",  dc_wdata,  e_wdata);
    chk("dc_wmask",  dc_wmask,  e_wmask);
    chk("dc_op",     dc_op,     e_op);
    chk("ldu_ready", ldu_ready, e_ldu_ready);
    chk("sq_ready",  sq_ready,  e_sq_ready);
    chk("ldu_done",  ldu_done,  e_ldu_done);
    chk("sq_done",   sq_done,   e_sq_done);
    chk("ldu_rdata", ldu_rdata, e_ldu_rdata);
    chk("sq_rdata",  sq_rdata,  e_sq_rdata);
    if (log_en && dc_valid && dc_ready) grant_log.push_back(sq_ready);
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  initial begin
    bit exp_order[6];
    bit ldu_acc, sq_acc;

    reset = 1; flush_valid = 0;
    ldu_valid = 0; ldu_index = 0; ldu_wdata = 0; ldu_wmask = 0; ldu_op = 0;
    sq_valid = 0; sq_index = 0; sq_wdata = 0; sq_wmask = 0; sq_op = 0;
    dc_ready = 0; dc_done = 0; dc_rdata = 0;
    q.delete(); streak = 0; log_en = 0;
    #1;
    cyc(); cyc();
    reset = 0;

    // Idle after reset, then a stray done in IDLE.
    settle();
    chk("rst_dc_valid", dc_valid, 0);
    chk("rst_sq_rdata", sq_rdata, 0);
    tick();
    dc_done = 1; dc_rdata = 64'hAAAA;
    settle();
    chk("idle_done_sq", sq_done, 0);
    chk("idle_done_ldu", ldu_done, 0);
    tick();
    dc_done = 0; dc_rdata = 0;

    // SQ-only store, done three cycles after the fire.
    sq_valid = 1; sq_index = 64'h8000_0040; sq_wdata = 64'hDEAD_BEEF;
    sq_wmask = 64'hFF; sq_op = 2'd1; dc_ready = 1;
    settle();
    chk("sq_fwd_index", dc_index, 64'h8000_0040);
    chk("sq_fwd_ready", sq_ready, 1);
    tick();
    sq_valid = 0;
    cyc(); cyc();
    dc_done = 1; dc_rdata = 64'h55;
    settle();
    chk("sq_done_pulse", sq_done, 1);
    tick();
    dc_done = 0; dc_rdata = 0;
    settle();
    chk("sq_done_once", sq_done, 0);
    tick();

    // Both valid: LDU first, SQ waits through the LDU operation.
    ldu_valid = 1; ldu_index = 64'h100; ldu_op = 2'd0;
    sq_valid = 1; sq_index = 64'h200;
    settle();
    chk("both_ldu_ready", ldu_ready, 1);
    chk("both_sq_ready", sq_ready, 0);
    tick();
    ldu_valid = 0;
    settle();
    chk("busy_sq_ready", sq_ready, 0);
    tick();
    dc_done = 1; dc_rdata = 64'h77;
    settle();
    chk("ldu_done_pulse", ldu_done, 1);
    chk("done_cycle_sq_ready", sq_ready, 0);
    tick();
    dc_done = 0;
    settle();
    chk("sq_after_ldu", sq_ready, 1);
    tick();
    sq_valid = 0; dc_done = 1;
    cyc();
    dc_done = 0;

    // Flushed LDU read: no done, data still routed; SQ granted afterwards.
    ldu_valid = 1; ldu_index = 64'h300; ldu_op = 2'd0;
    cyc();
    ldu_valid = 0; flush_valid = 1;
    cyc();
    flush_valid = 0; dc_done = 1; dc_rdata = 64'h1234;
    settle();
    chk("flush_ldu_done", ldu_done, 0);
    chk("flush_ldu_rdata", ldu_rdata, 64'h1234);
    tick();
    dc_done = 0; dc_rdata = 0; sq_valid = 1; sq_index = 64'h400;
    settle();
    chk("post_flush_sq_ready", sq_ready, 1);
    tick();
    sq_valid = 0; dc_done = 1;
    settle();
    chk("post_flush_sq_done", sq_done, 1);
    tick();
    dc_done = 0;

    // Continuous contention: grant order with and without starvation relief.
    ldu_valid = 1; sq_valid = 1; log_en = 1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      dc_done = 1;
      cyc();
      dc_done = 0;
    end
    log_en = 0; ldu_valid = 0; sq_valid = 0;
    for (int k = 0; k < 6; k++) exp_order[k] = STARVE && (k == 2 || k == 5);
    n_cmp++;
    if (grant_log.size() != 6) begin
      n_bad++;
      $display("FAIL grant_count: got %0d expected 6", grant_log.size());
    end
    for (int k = 0; k < 6 && k < grant_log.size(); k++)
      chk($sformatf("grant_order[%0d]", k), grant_log[k], exp_order[k]);
    cyc();

    // Reset while BUSY with the SQ as owner abandons the operation.
    sq_valid = 1; sq_index = 64'h500;
    cyc();
    sq_valid = 0; reset = 1;
    cyc();
    reset = 0; dc_done = 1;
    settle();
    chk("rst_busy_sq_done", sq_done, 0);
    tick();
    dc_done = 0; sq_valid = 1;
    settle();
    chk("rst_busy_regrant", sq_ready, 1);
    tick();
    sq_valid = 0; dc_done = 1;
    cyc();
    dc_done = 0;

    // Randomized phase; requesters hold until accepted.
    ldu_acc = 0; sq_acc = 0;
    for (int c = 0; c < 4000; c++) begin
      if (!ldu_valid || ldu_acc) begin
        ldu_valid = ($urandom_range(0, 2) != 0);
        ldu_index = {$urandom, $urandom}; ldu_wdata = {$urandom, $urandom};
        ldu_wmask = {$urandom, $urandom}; ldu_op = 2'($urandom_range(0, 3));
      end
      if (!sq_valid || sq_acc) begin
        sq_valid = ($urandom_range(0, 2) != 0);
        sq_index = {$urandom, $urandom}; sq_wdata = {$urandom, $urandom};
        sq_wmask = {$urandom, $urandom}; sq_op = 2'($urandom_range(0, 3));
      end
      flush_valid = ($urandom_range(0, 9) == 0);
      dc_ready    = ($urandom_range(0, 9) < 7);
      dc_done     = ($urandom_range(0, 2) == 0);
      dc_rdata    = {$urandom, $urandom};
      reset       = ($urandom_range(0, 199) == 0);
      settle();
      ldu_acc = e_ldu_ready;
      sq_acc  = e_sq_ready;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
